io_port_controller: RTL and testbench

Memory-mapped I/O block on the data side of the pipelined MIPS core. It decodes MEM-stage loads and stores in the 0xFFFF0000–0xFFFF001F window and holds a 32-bit output port register that drives the core's `PortOut`. It synchronizes the 8-bit `PortIn` and latches rising edges into sticky flags. It also provides a 32-bit free-running timer with compare match. Its read data is merged with data-memory read data ahead of the MEM/WB pipeline register.

---
 rtl/io_port_controller.sv | 72 +++++++
 tb/tb_io_port_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/io_port_controller.sv
// io_port_controller: memory-mapped output port, synchronized input port with
// sticky rise flags, and a 32-bit free-running timer with compare match.
module io_port_controller #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic                IOSelect,
    output logic [31:0]         ReadData,
    output logic [31:0]         PortOut,
    output logic                TimerMatch
);
    logic [IN_WIDTH-1:0] s1, s2, s3, in_edge, rise;
    logic [31:0] port_out, count, cmp;
    logic        en, autoclr, match, hit, wr;
    logic [2:0]  off;
    logic        unused_addr;

    assign unused_addr = ^Address[1:0];
    assign IOSelect    = (Address[31:5] == BASE_ADDR[31:5]) && (MemRead || MemWrite);
    assign wr          = MemWrite && IOSelect;
    assign off         = Address[4:2];
    assign rise        = s2 & ~s3;
    assign hit         = en && (count == cmp);
    assign PortOut     = port_out;
    assign TimerMatch  = match;

    assign ReadData = !IOSelect    ? 32'd0 :
                      off == 3'd0 ? port_out :
                      off == 3'd1 ? 32'(s2) :
                      off == 3'd2 ? 32'(in_edge) :
                      off == 3'd3 ? count :
                      off == 3'd4 ? cmp :
                      off == 3'd5 ? {29'd0, match, autoclr, en} : 32'd0;

    // new rises and matches are OR'd in after W1C so a same-cycle event survives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            in_edge  <= '0;
            port_out <= '0;
            count    <= '0;
            cmp      <= '0;
            en       <= 1'b0;
            autoclr  <= 1'b0;
            match    <= 1'b0;
        end else begin
            s1      <= PortIn;
            s2      <= s1;
            s3      <= s2;
            in_edge <= ((wr && off == 3'd2) ? in_edge & ~WriteData[IN_WIDTH-1:0] : in_edge) | rise;
            if (wr && off == 3'd0) port_out <= WriteData;
            count   <= (wr && off == 3'd3) ? WriteData :
                       (hit && autoclr)    ? 32'd0 :
                       en                  ? count + 32'd1 : count;
            if (wr && off == 3'd4) cmp <= WriteData;
            if (wr && off == 3'd5) begin
                en      <= WriteData[0];
                autoclr <= WriteData[1];
            end
            match   <= ((wr && off == 3'd5) ? match & ~WriteData[2] : match) | hit;
        end
    end
endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: directed vectors with hand-computed expectations.
module tb_io_port_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = '0;
    logic        IOSelect;
    logic [31:0] ReadData;
    logic [31:0] PortOut;
    logic        TimerMatch;
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [31:0] A_OUT = 32'hFFFF0000, A_IN = 32'hFFFF0004, A_EDGE = 32'hFFFF0008,
                            A_CNT = 32'hFFFF000C, A_CMP = 32'hFFFF0010, A_CTRL = 32'hFFFF0014;

    io_port_controller dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn), .IOSelect(IOSelect),
        .ReadData(ReadData), .PortOut(PortOut), .TimerMatch(TimerMatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a; MemRead = 1'b1;
        #1;
        chk(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_match", {31'd0, TimerMatch}, 32'h0);
        chk("rst_iosel", {31'd0, IOSelect}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        rd("rst_count", A_CNT, 32'h0);

        st(A_OUT, 32'hA5A51234);
        chk("portout_wr", PortOut, 32'hA5A51234);
        Address = A_OUT; MemRead = 1'b1; #1;
        chk("iosel_rd", {31'd0, IOSelect}, 32'h1);
        MemRead = 1'b0; #1;
        chk("iosel_nostrobe", {31'd0, IOSelect}, 32'h0);
        chk("rdata_nostrobe", ReadData, 32'h0);
        rd("portout_rd", A_OUT, 32'hA5A51234);

        PortIn = 8'h81;
        tick();
        rd("portin_1edge", A_IN, 32'h0);
        tick();
        rd("portin_2edge", A_IN, 32'h81);
        rd("edge_2edge", A_EDGE, 32'h0);
        tick();
        rd("edge_3edge", A_EDGE, 32'h81);
        st(A_EDGE, 32'h1);
        rd("edge_w1c", A_EDGE, 32'h80);

        PortIn = 8'h80;
        repeat (3) tick();
        rd("edge_nofall", A_EDGE, 32'h80);
        PortIn = 8'h81;
        tick();
        tick();
        st(A_EDGE, 32'h1);
        rd("edge_setwins", A_EDGE, 32'h81);

        st(A_CMP, 32'd5);
        st(A_CNT, 32'd0);
        st(A_CTRL, 32'h3);
        rd("cnt_start", A_CNT, 32'd0);
        repeat (5) tick();
        rd("cnt_at5", A_CNT, 32'd5);
        chk("match_pre", {31'd0, TimerMatch}, 32'h0);
        tick();
        chk("match_set", {31'd0, TimerMatch}, 32'h1);
        rd("cnt_autoclr", A_CNT, 32'd0);
        rd("ctrl_rd", A_CTRL, 32'h7);
        tick();
        rd("cnt_after", A_CNT, 32'd1);
        chk("match_sticky", {31'd0, TimerMatch}, 32'h1);
        st(A_CTRL, 32'h4);
        chk("match_w1c", {31'd0, TimerMatch}, 32'h0);
        rd("ctrl_cleared", A_CTRL, 32'h0);

        st(A_CTRL, 32'h1);
        st(A_CNT, 32'hFFFFFFFE);
        rd("cnt_load", A_CNT, 32'hFFFFFFFE);
        tick();
        rd("cnt_ff", A_CNT, 32'hFFFFFFFF);
        tick();
        rd("cnt_wrap", A_CNT, 32'h0);
        tick();
        rd("cnt_one", A_CNT, 32'h1);

        Address = 32'h10010000; WriteData = 32'hDEADBEEF; MemWrite = 1'b1; MemRead = 1'b1; #1;
        chk("ram_iosel", {31'd0, IOSelect}, 32'h0);
        chk("ram_rdata", ReadData, 32'h0);
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("ram_nowrite", PortOut, 32'hA5A51234);
        rd("hole18_rd", 32'hFFFF0018, 32'h0);
        st(32'hFFFF0018, 32'hDEADBEEF);
        rd("hole18_after", 32'hFFFF0018, 32'h0);
        st(32'hFFFF001C, 32'hDEADBEEF);
        rd("hole1c_rd", 32'hFFFF001C, 32'h0);
        chk("hole_nowrite", PortOut, 32'hA5A51234);

        Address = A_OUT; WriteData = 32'h12345678; MemWrite = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("midrst_portout", PortOut, 32'h0);
        chk("midrst_match", {31'd0, TimerMatch}, 32'h0);
        tick();
        MemWrite = 1'b0;
        chk("midrst_abort", PortOut, 32'h0);
        reset = 1'b1;
        rd("midrst_portin", A_IN, 32'h0);
        rd("midrst_edge", A_EDGE, 32'h0);
        rd("midrst_count", A_CNT, 32'h0);
        st(A_OUT, 32'h0000BEEF);
        chk("post_rst_wr", PortOut, 32'h0000BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
